cnn_accel_ahb_regs: RTL and testbench

AHB-Lite slave register file for the CNN accelerator, sitting between the system AHB bus (driven by the RISC-V core) and the accelerator datapath/DMA. It holds the frame geometry, the delay, base-address and layer configuration, and issues one-cycle layer-start and image-load-start pulses. It keeps sticky done/busy status that firmware polls to sequence layers.

---
 rtl/cnn_accel_ahb_regs.sv | 226 ++++++++++++++++++++++
 tb/tb_cnn_accel_ahb_regs.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_accel_ahb_regs.sv
// AHB-Lite register file for the CNN accelerator: frame geometry, delays, base
// addresses and layer configuration, plus layer/image-load start pulses and sticky status.
module cnn_accel_ahb_regs #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int N_REGS = 21
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [W_ADDR-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [W_DATA-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [W_DATA-1:0] HRDATA,
  output logic [24:0]       cfg_frame_size,
  output logic [11:0]       cfg_width,
  output logic [11:0]       cfg_height,
  output logic [11:0]       cfg_start_up_delay,
  output logic [11:0]       cfg_hsync_delay,
  output logic [19:0]       cfg_base_weight,
  output logic [11:0]       cfg_base_param,
  output logic [15:0]       cfg_layer_config,
  output logic [31:0]       cfg_image_base,
  output logic              layer_start,
  input  logic              layer_done_in,
  output logic              load_start,
  input  logic              load_done_in
);

  localparam int W_REGS = $clog2(N_REGS);

  localparam logic [W_REGS-1:0] R_FRAME  = W_REGS'(0);
  localparam logic [W_REGS-1:0] R_WH     = W_REGS'(1);
  localparam logic [W_REGS-1:0] R_DELAY  = W_REGS'(2);
  localparam logic [W_REGS-1:0] R_BASE   = W_REGS'(3);
  localparam logic [W_REGS-1:0] R_LCFG   = W_REGS'(4);
  localparam logic [W_REGS-1:0] R_LSTART = W_REGS'(5);
  localparam logic [W_REGS-1:0] R_LDONE  = W_REGS'(6);
  localparam logic [W_REGS-1:0] R_IBASE  = W_REGS'(7);
  localparam logic [W_REGS-1:0] R_ILOAD  = W_REGS'(8);

  logic [W_REGS-1:0] a_idx;
  logic              acc, legal, wr;
  logic [31:0]       wd, rd;
  logic              unused_bits;

  logic              dp_wr_q, dp_wr_d;
  logic [W_REGS-1:0] dp_idx_q, dp_idx_d;
  logic              err1_q, err1_d, err2_q, err2_d;
  logic [W_DATA-1:0] rdata_q, rdata_d;
  logic [24:0]       frame_q, frame_d;
  logic [11:0]       width_q, width_d, height_q, height_d;
  logic [11:0]       su_delay_q, su_delay_d, hs_delay_q, hs_delay_d;
  logic [19:0]       base_w_q, base_w_d;
  logic [11:0]       base_p_q, base_p_d;
  logic [15:0]       layer_cfg_q, layer_cfg_d;
  logic [31:0]       image_base_q, image_base_d;
  logic              start_bit_q, start_bit_d, busy_q, busy_d, done_q, done_d;
  logic              load_bit_q, load_bit_d, load_busy_q, load_busy_d, load_done_q, load_done_d;
  logic              layer_start_q, layer_start_d, load_start_q, load_start_d;

  assign a_idx       = HADDR[W_REGS+1:2];
  assign acc         = HSEL & HREADY & HTRANS[1];
  assign legal       = (HSIZE == 3'b010) && (int'(a_idx) < N_REGS);
  assign wr          = dp_wr_q & HREADY;
  assign wd          = HWDATA[31:0];
  assign unused_bits = ^{HADDR[W_ADDR-1:W_REGS+2], HADDR[1:0], HTRANS[0]};

  always_comb begin
    dp_wr_d       = HREADY ? (acc & legal & HWRITE) : dp_wr_q;
    dp_idx_d      = acc ? a_idx : dp_idx_q;
    err1_d        = acc & ~legal;
    err2_d        = err1_q;
    frame_d       = frame_q;
    width_d       = width_q;
    height_d      = height_q;
    su_delay_d    = su_delay_q;
    hs_delay_d    = hs_delay_q;
    base_w_d      = base_w_q;
    base_p_d      = base_p_q;
    layer_cfg_d   = layer_cfg_q;
    image_base_d  = image_base_q;
    start_bit_d   = start_bit_q;
    busy_d        = busy_q;
    done_d        = done_q;
    load_bit_d    = load_bit_q;
    load_busy_d   = load_busy_q;
    load_done_d   = load_done_q;
    layer_start_d = 1'b0;
    load_start_d  = 1'b0;

    if (wr) begin
      case (dp_idx_q)
        R_FRAME: frame_d = wd[24:0];
        R_WH: begin
          width_d  = wd[11:0];
          height_d = wd[27:16];
        end
        R_DELAY: begin
          su_delay_d = wd[11:0];
          hs_delay_d = wd[23:12];
        end
        R_BASE: begin
          base_w_d = wd[19:0];
          base_p_d = wd[31:20];
        end
        R_LCFG: layer_cfg_d = wd[15:0];
        R_LSTART: begin
          start_bit_d = wd[0];
          if (wd[0] && !start_bit_q && !busy_q) begin
            layer_start_d = 1'b1;
            busy_d        = 1'b1;
            done_d        = 1'b0;
          end
        end
        R_IBASE: image_base_d = wd;
        R_ILOAD: begin
          load_bit_d = wd[0];
          if (wd[0] && !load_bit_q && !load_busy_q) begin
            load_start_d = 1'b1;
            load_busy_d  = 1'b1;
            load_done_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // Completion overrides a start committed on the same edge.
    if (layer_done_in) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (load_done_in) begin
      load_busy_d = 1'b0;
      load_done_d = 1'b1;
    end

    // Read mux uses next-state values so a read right behind a write sees the new data.
    rd = '0;
    case (a_idx)
      R_FRAME:  rd = {7'b0, frame_d};
      R_WH:     rd = {4'b0, height_d, 4'b0, width_d};
      R_DELAY:  rd = {8'b0, hs_delay_d, su_delay_d};
      R_BASE:   rd = {base_p_d, base_w_d};
      R_LCFG:   rd = {16'b0, layer_cfg_d};
      R_LSTART: rd = {31'b0, start_bit_d};
      R_LDONE:  rd = {30'b0, busy_d, done_d};
      R_IBASE:  rd = image_base_d;
      R_ILOAD:  rd = {30'b0, load_busy_d, load_done_d};
      default:  rd = '0;
    endcase
    rdata_d = HREADY ? ((acc && legal && !HWRITE) ? W_DATA'(rd) : '0) : rdata_q;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_wr_q       <= 1'b0;
      dp_idx_q      <= '0;
      err1_q        <= 1'b0;
      err2_q        <= 1'b0;
      rdata_q       <= '0;
      frame_q       <= '0;
      width_q       <= '0;
      height_q      <= '0;
      su_delay_q    <= '0;
      hs_delay_q    <= '0;
      base_w_q      <= '0;
      base_p_q      <= '0;
      layer_cfg_q   <= '0;
      image_base_q  <= '0;
      start_bit_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_bit_q    <= 1'b0;
      load_busy_q   <= 1'b0;
      load_done_q   <= 1'b0;
      layer_start_q <= 1'b0;
      load_start_q  <= 1'b0;
    end else begin
      dp_wr_q       <= dp_wr_d;
      dp_idx_q      <= dp_idx_d;
      err1_q        <= err1_d;
      err2_q        <= err2_d;
      rdata_q       <= rdata_d;
      frame_q       <= frame_d;
      width_q       <= width_d;
      height_q      <= height_d;
      su_delay_q    <= su_delay_d;
      hs_delay_q    <= hs_delay_d;
      base_w_q      <= base_w_d;
      base_p_q      <= base_p_d;
      layer_cfg_q   <= layer_cfg_d;
      image_base_q  <= image_base_d;
      start_bit_q   <= start_bit_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      load_bit_q    <= load_bit_d;
      load_busy_q   <= load_busy_d;
      load_done_q   <= load_done_d;
      layer_start_q <= layer_start_d;
      load_start_q  <= load_start_d;
    end
  end

  assign HREADYOUT          = ~err1_q;
  assign HRESP              = err1_q | err2_q;
  assign HRDATA             = rdata_q;
  assign cfg_frame_size     = frame_q;
  assign cfg_width          = width_q;
  assign cfg_height         = height_q;
  assign cfg_start_up_delay = su_delay_q;
  assign cfg_hsync_delay    = hs_delay_q;
  assign cfg_base_weight    = base_w_q;
  assign cfg_base_param     = base_p_q;
  assign cfg_layer_config   = layer_cfg_q;
  assign cfg_image_base     = image_base_q;
  assign layer_start        = layer_start_q;
  assign load_start         = load_start_q;

endmodule

// File: tb/tb_cnn_accel_ahb_regs.sv
// Directed bench for cnn_accel_ahb_regs: a word-array register model updated per bus
// edge, checked every cycle, plus literal expectations from the register map.
module tb_cnn_accel_ahb_regs;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [24:0] cfg_frame_size;
  logic [11:0] cfg_width, cfg_height, cfg_start_up_delay, cfg_hsync_delay, cfg_base_param;
  logic [19:0] cfg_base_weight;
  logic [15:0] cfg_layer_config;
  logic [31:0] cfg_image_base;
  logic        layer_start, layer_done_in, load_start, load_done_in;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  cnn_accel_ahb_regs #(.W_ADDR(32), .W_DATA(32), .N_REGS(21)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .cfg_frame_size(cfg_frame_size), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_start_up_delay(cfg_start_up_delay), .cfg_hsync_delay(cfg_hsync_delay),
    .cfg_base_weight(cfg_base_weight), .cfg_base_param(cfg_base_param),
    .cfg_layer_config(cfg_layer_config), .cfg_image_base(cfg_image_base),
    .layer_start(layer_start), .layer_done_in(layer_done_in),
    .load_start(load_start), .load_done_in(load_done_in)
  );

  // Model state: register words 0..8 (stored bits only) and status flags
  logic [31:0] m_reg [0:8];
  logic        m_busy, m_done, m_lbusy, m_ldone;
  logic        exp_ls, exp_lds, exp_ready, exp_resp, rd_chk, dp_wr;
  logic [31:0] exp_rdata;
  logic [4:0]  dp_idx;
  logic        last_ready, last_resp;
  int          vectors = 0, miscompares = 0, ls_count = 0, lds_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int idx);
    case (idx)
      0:       return 32'h01FF_FFFF;
      1:       return 32'h0FFF_0FFF;
      2:       return 32'h00FF_FFFF;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_FFFF;
      5:       return 32'h0000_0001;
      7:       return 32'hFFFF_FFFF;
      8:       return 32'h0000_0001;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    if (idx == 6) return {30'b0, m_busy, m_done};
    if (idx == 8) return {30'b0, m_lbusy, m_ldone};
    if (idx < 9) return m_reg[idx];
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_reg[i] = 32'h0;
    m_busy = 0; m_done = 0; m_lbusy = 0; m_ldone = 0;
    exp_ls = 0; exp_lds = 0; exp_ready = 1; exp_resp = 0;
    rd_chk = 0; exp_rdata = 0; dp_wr = 0; dp_idx = 0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d);
    if (idx == 5 && d[0] && !m_reg[5][0] && !m_busy) begin
      exp_ls = 1; m_busy = 1; m_done = 0;
    end
    if (idx == 8 && d[0] && !m_reg[8][0] && !m_lbusy) begin
      exp_lds = 1; m_lbusy = 1; m_ldone = 0;
    end
    if (idx < 9 && idx != 6) m_reg[idx] = d & mask_of(idx);
  endtask

  // Advance one clock; apply to the model whatever the bus did across that edge
  task automatic tick();
    logic s_acc, s_legal, s_write, s_dpwr, s_ld, s_lld, old_ready;
    logic [4:0]  s_idx, s_dpidx;
    logic [31:0] s_wdata;
    s_idx   = HADDR[6:2];
    s_acc   = HSEL && HTRANS[1] && exp_ready;
    s_legal = (HSIZE == 3'b010) && (s_idx < 5'd21);
    s_write = HWRITE;
    s_dpwr  = dp_wr;
    s_dpidx = dp_idx;
    s_wdata = HWDATA;
    s_ld    = layer_done_in;
    s_lld   = load_done_in;
    @(posedge HCLK); #1;
    old_ready = exp_ready;
    exp_ls = 0; exp_lds = 0;
    if (s_dpwr) model_write(int'(s_dpidx), s_wdata);
    if (s_ld) begin m_busy = 0; m_done = 1; end
    if (s_lld) begin m_lbusy = 0; m_ldone = 1; end
    if (s_acc && !s_legal) begin exp_ready = 0; exp_resp = 1; end
    else if (!old_ready)   begin exp_ready = 1; exp_resp = 1; end
    else                   begin exp_ready = 1; exp_resp = 0; end
    if (old_ready) begin
      dp_wr     = s_acc && s_legal && s_write;
      dp_idx    = s_idx;
      rd_chk    = s_acc && (!s_write || !s_legal);
      exp_rdata = (s_acc && s_legal && !s_write) ? model_read(int'(s_idx)) : 32'h0;
    end
  endtask

  task automatic bus_idle();
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
  endtask

  task automatic addr_phase(input int idx, input logic wr, input logic [2:0] sz);
    HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = 32'(idx) << 2; HSIZE = sz;
  endtask

  task automatic bus_write(input int idx, input logic [31:0] d,
                           input logic [2:0] sz = 3'b010, input logic with_done = 1'b0);
    addr_phase(idx, 1'b1, sz);
    tick();
    bus_idle();
    HWDATA = d;
    layer_done_in = with_done;
    @(negedge HCLK);
    last_ready = HREADYOUT;
    last_resp  = HRESP;
    tick();
    layer_done_in = 0;
    if (exp_resp) tick();
  endtask

  task automatic bus_read(input int idx, output logic [31:0] d);
    addr_phase(idx, 1'b0, 3'b010);
    tick();
    bus_idle();
    @(negedge HCLK);
    d = HRDATA;
    tick();
  endtask

  task automatic wr_then_rd(input int idx, input logic [31:0] wdat, output logic [31:0] d);
    addr_phase(idx, 1'b1, 3'b010);
    tick();
    addr_phase(idx, 1'b0, 3'b010);
    HWDATA = wdat;
    tick();
    bus_idle();
    @(negedge HCLK);
    d = HRDATA;
    tick();
  endtask

  task automatic pulse_layer_done();
    layer_done_in = 1; tick(); layer_done_in = 0;
  endtask

  task automatic pulse_load_done();
    load_done_in = 1; tick(); load_done_in = 0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge HCLK) begin
    chk("hreadyout", 32'(HREADYOUT), 32'(exp_ready));
    chk("hresp", 32'(HRESP), 32'(exp_resp));
    chk("frame_size", 32'(cfg_frame_size), m_reg[0]);
    chk("width", 32'(cfg_width), 32'(m_reg[1][11:0]));
    chk("height", 32'(cfg_height), 32'(m_reg[1][27:16]));
    chk("start_up_delay", 32'(cfg_start_up_delay), 32'(m_reg[2][11:0]));
    chk("hsync_delay", 32'(cfg_hsync_delay), 32'(m_reg[2][23:12]));
    chk("base_weight", 32'(cfg_base_weight), 32'(m_reg[3][19:0]));
    chk("base_param", 32'(cfg_base_param), 32'(m_reg[3][31:20]));
    chk("layer_config", 32'(cfg_layer_config), 32'(m_reg[4][15:0]));
    chk("image_base", cfg_image_base, m_reg[7]);
    chk("layer_start", 32'(layer_start), 32'(exp_ls));
    chk("load_start", 32'(load_start), 32'(exp_lds));
    if (rd_chk) chk("hrdata", HRDATA, exp_rdata);
    if (layer_start === 1'b1) ls_count++;
    if (load_start === 1'b1) lds_count++;
  end

  initial begin
    logic [31:0] r;
    int c0;
    model_reset();
    HRESET = 1; bus_idle(); HADDR = 0; HSIZE = 3'b010; HWDATA = 0;
    layer_done_in = 0; load_done_in = 0; last_ready = 1; last_resp = 0;
    tick(); tick();
    HRESET = 0;
    tick();
    chk("lit_rst_ready", 32'(HREADYOUT), 32'h1);
    chk("lit_rst_frame", 32'(cfg_frame_size), 32'h0);

    // Geometry
    bus_write(0, 32'h0000_4000);
    bus_write(1, 32'h0080_0080);
    chk("lit_frame", 32'(cfg_frame_size), 32'h4000);
    chk("lit_width", 32'(cfg_width), 32'd128);
    chk("lit_height", 32'(cfg_height), 32'd128);
    bus_read(0, r); chk("lit_rd_frame", r, 32'h0000_4000);
    bus_read(1, r); chk("lit_rd_wh", r, 32'h0080_0080);

    // Layer start / done
    bus_write(4, 32'h0000_E90B);
    chk("lit_lcfg", 32'(cfg_layer_config), 32'hE90B);
    c0 = ls_count;
    bus_write(5, 32'h1);
    bus_write(5, 32'h0);
    chk("lit_one_pulse", 32'(ls_count - c0), 32'd1);
    bus_read(6, r); chk("lit_busy", r, 32'h2);
    pulse_layer_done();
    bus_read(6, r); chk("lit_done", r, 32'h1);

    // Start ignored while busy; done coinciding with a start commit
    c0 = ls_count;
    bus_write(5, 32'h1);
    bus_write(5, 32'h0);
    bus_write(5, 32'h1);
    chk("lit_busy_ignore", 32'(ls_count - c0), 32'd1);
    bus_read(6, r); chk("lit_still_busy", r, 32'h2);
    bus_read(5, r); chk("lit_start_bit", r, 32'h1);
    bus_write(5, 32'h0);
    pulse_layer_done();
    bus_write(5, 32'h1, 3'b010, 1'b1);
    bus_read(6, r); chk("lit_coincide", r, 32'h1);

    // Image load
    bus_write(7, 32'h2000_0000);
    chk("lit_ibase", cfg_image_base, 32'h2000_0000);
    c0 = lds_count;
    bus_write(8, 32'h1);
    for (int i = 0; i < 3; i++) begin
      bus_read(8, r); chk("lit_load_busy", r, 32'h2);
    end
    chk("lit_load_pulse", 32'(lds_count - c0), 32'd1);
    pulse_load_done();
    bus_read(8, r); chk("lit_load_done", r, 32'h1);

    // Illegal accesses
    bus_write(25, 32'hDEAD_BEEF);
    chk("lit_err_idx_ready", 32'(last_ready), 32'h0);
    chk("lit_err_idx_resp", 32'(last_resp), 32'h1);
    bus_write(0, 32'h0000_FFFF, 3'b000);
    chk("lit_err_size_ready", 32'(last_ready), 32'h0);
    chk("lit_err_size_resp", 32'(last_resp), 32'h1);
    bus_read(0, r); chk("lit_reg0_kept", r, 32'h0000_4000);
    bus_read(9, r); chk("lit_reserved", r, 32'h0);

    // Write-to-read forwarding
    wr_then_rd(2, 32'h00AB_C123, r);
    chk("lit_forward", r, 32'h00AB_C123);
    chk("lit_su_delay", 32'(cfg_start_up_delay), 32'h123);
    chk("lit_hs_delay", 32'(cfg_hsync_delay), 32'hABC);

    // Reset during the data phase of a DELAY_PARAMS write
    addr_phase(2, 1'b1, 3'b010);
    tick();
    bus_idle();
    HWDATA = 32'h0012_3456;
    #3;
    HRESET = 1;
    model_reset();
    tick();
    HRESET = 0;
    tick();
    bus_read(2, r); chk("lit_rst_delay", r, 32'h0);
    bus_read(0, r); chk("lit_rst_frame2", r, 32'h0);
    chk("lit_rst_lcfg", 32'(cfg_layer_config), 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
